// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect
// from execute, and the held-instruction handoff to decode.
interface instr_fetch_stage_if #(
  parameter int unsigned XLEN = 32
) ();
  localparam int unsigned ILEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_target;
  logic            decode_ready;
  logic            instr_valid;
  logic [ILEN-1:0] instr;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pcplus4_out;

  // Fetch stage side
  modport master (
    output imem_req, imem_addr, instr_valid, instr, pc_out, pcplus4_out,
    input  imem_rvalid, imem_rdata, pc_redirect, pc_target, decode_ready
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, pc_out, pcplus4_out,
    output imem_rvalid, imem_rdata, pc_redirect, pc_target, decode_ready
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request in flight and
// holds the fetched instruction for decode; redirects flush and drop responses.
module instr_fetch_stage #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  instr_fetch_stage_if.master  bus
);
  localparam int unsigned ILEN = 32;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [ILEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_out_q, pc_out_d;
  logic [XLEN-1:0] pcplus4_q, pcplus4_d;
  logic            valid_q, valid_d;
  logic            req_c;
  logic [XLEN-1:0] target_c;

  // Redirect target is always word aligned
  assign target_c = bus.pc_target & ~XLEN'(3);

  // State register and held-instruction registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc_out_q  <= '0;
      pcplus4_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc_out_q  <= pc_out_d;
      pcplus4_q <= pcplus4_d;
      valid_q   <= valid_d;
    end
  end

  // Next-state and request logic; redirect wins over rvalid and decode_ready
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc_out_d  = pc_out_q;
    pcplus4_d = pcplus4_q;
    valid_d   = valid_q;
    req_c     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (bus.pc_redirect) begin
          pc_d = target_c;
        end else begin
          req_c   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.pc_redirect) begin
          pc_d    = target_c;
          state_d = bus.imem_rvalid ? S_FETCH : S_DROP;
        end else if (bus.imem_rvalid) begin
          instr_d   = bus.imem_rdata;
          pc_out_d  = pc_q;
          pcplus4_d = pc_q + XLEN'(4);
          valid_d   = 1'b1;
          pc_d      = pc_q + XLEN'(4);
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.pc_redirect) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          pc_d    = target_c;
          state_d = S_FETCH;
        end else if (bus.decode_ready) begin
          req_c   = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (bus.pc_redirect) pc_d = target_c;
        if (bus.imem_rvalid) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Request is suppressed while reset is held so nothing escapes before release
  assign bus.imem_req    = req_c & ~reset;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.pcplus4_out = pcplus4_q;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage with a response scoreboard.
module tb_instr_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_rise = 0;
  logic prev_v = 1'b0;
  exp_t sb[$];

  instr_fetch_stage_if #(.XLEN(32)) bus ();

  instr_fetch_stage #(
    .XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; outputs are sampled 1ns after the edge and valid rises are scored
  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.instr_valid === 1'b1 && prev_v !== 1'b1) begin
      n_rise++;
      if (sb.size() == 0) begin
        chk("sb_spurious_valid", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", bus.instr, e.ins);
        chk("sb_pc_out", bus.pc_out, e.pc);
        chk("sb_pcplus4", bus.pcplus4_out, 32'(e.pc + 32'd4));
      end
    end
    prev_v = bus.instr_valid;
  endtask

  // Expect a request at addr now, answer it after one cycle, expect it held
  task automatic fetch_resp(input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    #1;
    chk("req_asserted", 32'(bus.imem_req), 32'd1);
    chk("req_addr", bus.imem_addr, addr);
    cyc();
    chk("wait_no_req", 32'(bus.imem_req), 32'd0);
    chk("wait_invalid", 32'(bus.instr_valid), 32'd0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    e.pc = addr;
    e.ins = data;
    sb.push_back(e);
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
  endtask

  initial begin
    int rises_before;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = '0;
    bus.pc_redirect  = 1'b0;
    bus.pc_target    = '0;
    bus.decode_ready = 1'b1;

    // Reset state
    repeat (2) cyc();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, NOP);
    chk("rst_pc_out", bus.pc_out, 32'd0);
    chk("rst_pcplus4", bus.pcplus4_out, 32'd0);
    reset = 1'b0;

    // 1: sequential fetch at one instruction per two cycles
    fetch_resp(32'h0, 32'h1111_0001);
    fetch_resp(32'h4, 32'h2222_0002);
    fetch_resp(32'h8, 32'h3333_0003);

    // 2: decode stall holds outputs; stray rvalid in HOLD is ignored
    bus.decode_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.imem_rvalid = (i == 2);
      bus.imem_rdata  = 32'hBAD0_BAD0;
      #1;
      chk("stall_no_req", 32'(bus.imem_req), 32'd0);
      cyc();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_instr", bus.instr, 32'h3333_0003);
      chk("stall_pc_out", bus.pc_out, 32'h8);
      chk("stall_pcplus4", bus.pcplus4_out, 32'hC);
    end
    bus.imem_rvalid  = 1'b0;
    bus.decode_ready = 1'b1;
    fetch_resp(32'hC, 32'h4444_0004);

    // 3: redirect while holding
    bus.pc_redirect = 1'b1;
    bus.pc_target   = 32'h100;
    #1;
    chk("redir_hold_no_req", 32'(bus.imem_req), 32'd0);
    cyc();
    bus.pc_redirect = 1'b0;
    chk("redir_hold_flush", 32'(bus.instr_valid), 32'd0);
    fetch_resp(32'h100, 32'h5555_0005);

    // 4: redirect mid-WAIT, late response must be dropped
    #1;
    chk("t4_req_addr", bus.imem_addr, 32'h104);
    cyc();
    rises_before = n_rise;
    bus.pc_redirect = 1'b1;
    bus.pc_target   = 32'h200;
    cyc();
    bus.pc_redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("drop_no_req", 32'(bus.imem_req), 32'd0);
      cyc();
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    cyc();
    bus.imem_rvalid = 1'b0;
    chk("drop_no_pulse", 32'(n_rise - rises_before), 32'd0);
    chk("drop_invalid", 32'(bus.instr_valid), 32'd0);
    fetch_resp(32'h200, 32'h6666_0006);

    // 5: redirect and rvalid together in WAIT; unaligned target is masked
    #1;
    chk("t5_req_addr", bus.imem_addr, 32'h204);
    cyc();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hCAFE_F00D;
    bus.pc_redirect = 1'b1;
    bus.pc_target   = 32'h303;
    cyc();
    bus.imem_rvalid = 1'b0;
    bus.pc_redirect = 1'b0;
    chk("t5_invalid", 32'(bus.instr_valid), 32'd0);
    fetch_resp(32'h300, 32'h7777_0007);

    // 6: PC wrap at the top of the address space
    bus.pc_redirect = 1'b1;
    bus.pc_target   = 32'hFFFF_FFFC;
    cyc();
    bus.pc_redirect = 1'b0;
    fetch_resp(32'hFFFF_FFFC, 32'h8888_0008);
    chk("wrap_pcplus4", bus.pcplus4_out, 32'h0);
    #1;
    chk("wrap_req_addr", bus.imem_addr, 32'h0);
    cyc();

    // Asynchronous reset in WAIT takes effect without a clock edge
    #1;
    reset = 1'b1;
    #1;
    chk("arst_req", 32'(bus.imem_req), 32'd0);
    chk("arst_valid", 32'(bus.instr_valid), 32'd0);
    chk("arst_instr", bus.instr, NOP);
    chk("arst_pc_out", bus.pc_out, 32'd0);
    chk("arst_pcplus4", bus.pcplus4_out, 32'd0);
    cyc();
    reset = 1'b0;
    fetch_resp(32'h0, 32'h9999_0009);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
